// File: rtl/sdram_arbiter.sv
// Three-port round-robin arbiter in front of a single SDRAM controller command port.
// Read tags are queued in issue order so in-order read returns are routed back to the requester.
module sdram_arbiter #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic [2:0]              req_valid_i,
  output logic [2:0]              req_ready_o,
  input  logic [2:0]              req_we_i,
  input  logic [3*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [3*DATA_WIDTH-1:0] req_wdata_i,
  output logic [2:0]              rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    ctrl_valid_o,
  input  logic                    ctrl_ready_i,
  output logic                    ctrl_we_o,
  output logic [ADDR_WIDTH-1:0]   ctrl_addr_o,
  output logic [DATA_WIDTH-1:0]   ctrl_wdata_o,
  input  logic                    ctrl_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   ctrl_rdata_i,
  output logic                    error_o
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              last_grant_q, last_grant_d;
  logic                    ctrl_we_q, ctrl_we_d;
  logic [ADDR_WIDTH-1:0]   ctrl_addr_q, ctrl_addr_d;
  logic [DATA_WIDTH-1:0]   ctrl_wdata_q, ctrl_wdata_d;

  logic [1:0]              tag_mem_q [TAG_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;

  logic [2:0]              rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    error_q, error_d;

  logic                    tag_full, tag_empty;
  logic [2:0]              eligible;
  logic [1:0]              c0, c1, c2;
  logic                    grant_vld;
  logic [1:0]              grant_idx;
  logic [2:0]              grant_oh;
  logic                    push, pop;

  assign tag_full  = (count_q == CNT_W'(TAG_DEPTH));
  assign tag_empty = (count_q == '0);
  // Writes never occupy a tag, so they stay eligible while the tag queue is full.
  assign eligible  = req_valid_i & (req_we_i | {3{~tag_full}});

  always_comb begin
    c0 = 2'd0;
    c1 = 2'd1;
    c2 = 2'd2;
    case (last_grant_q)
      2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
      2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
      default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ctrl_we_d    = ctrl_we_q;
    ctrl_addr_d  = ctrl_addr_q;
    ctrl_wdata_d = ctrl_wdata_q;
    grant_vld    = 1'b0;
    grant_idx    = 2'd0;
    grant_oh     = 3'b000;
    case (state_q)
      IDLE: begin
        if (eligible[c0]) begin
          grant_vld = 1'b1;
          grant_idx = c0;
        end else if (eligible[c1]) begin
          grant_vld = 1'b1;
          grant_idx = c1;
        end else if (eligible[c2]) begin
          grant_vld = 1'b1;
          grant_idx = c2;
        end
        if (grant_vld) begin
          grant_oh     = 3'b001 << grant_idx;
          state_d      = ISSUE;
          last_grant_d = grant_idx;
          ctrl_we_d    = req_we_i[grant_idx];
          for (int n = 0; n < 3; n++) begin
            if (grant_oh[n]) begin
              ctrl_addr_d  = req_addr_i[n*ADDR_WIDTH +: ADDR_WIDTH];
              ctrl_wdata_d = req_wdata_i[n*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
      ISSUE: begin
        if (ctrl_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign push = grant_vld & ~req_we_i[grant_idx];
  assign pop  = ctrl_rvalid_i & ~tag_empty;

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d     = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    rsp_valid_d = pop ? (3'b001 << tag_mem_q[rd_ptr_q]) : 3'b000;
    rsp_rdata_d = pop ? ctrl_rdata_i : rsp_rdata_q;
    error_d     = error_q | (ctrl_rvalid_i & tag_empty);
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q      <= IDLE;
      last_grant_q <= 2'd2;
      ctrl_we_q    <= 1'b0;
      ctrl_addr_q  <= '0;
      ctrl_wdata_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rsp_valid_q  <= 3'b000;
      rsp_rdata_q  <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ctrl_we_q    <= ctrl_we_d;
      ctrl_addr_q  <= ctrl_addr_d;
      ctrl_wdata_q <= ctrl_wdata_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      error_q      <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem_q[wr_ptr_q] <= grant_idx;
  end

  assign req_ready_o  = reset_i ? 3'b000 : grant_oh;
  assign ctrl_valid_o = (state_q == ISSUE);
  assign ctrl_we_o    = ctrl_we_q;
  assign ctrl_addr_o  = ctrl_addr_q;
  assign ctrl_wdata_o = ctrl_wdata_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: scripted ports and controller, scoreboard of expected read responses.
module tb_sdram_arbiter;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int TD = 4;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [2:0]      req_valid_i, req_ready_o, req_we_i;
  logic [3*AW-1:0] req_addr_i;
  logic [3*DW-1:0] req_wdata_i;
  logic [2:0]      rsp_valid_o;
  logic [DW-1:0]   rsp_rdata_o;
  logic            ctrl_valid_o, ctrl_ready_i, ctrl_we_o;
  logic [AW-1:0]   ctrl_addr_o;
  logic [DW-1:0]   ctrl_wdata_o;
  logic            ctrl_rvalid_i;
  logic [DW-1:0]   ctrl_rdata_i;
  logic            error_o;

  typedef struct packed {
    logic [1:0]    port;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t exp_rsp[$];
  int   iss_q[$];
  int   grant_log[$];
  int   tests = 0;
  int   fails = 0;
  bit   auto_ret = 1'b0;
  rsp_t mon_e;

  always #5 clk = ~clk;

  sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .ctrl_valid_o(ctrl_valid_o), .ctrl_ready_i(ctrl_ready_i), .ctrl_we_o(ctrl_we_o),
    .ctrl_addr_o(ctrl_addr_o), .ctrl_wdata_o(ctrl_wdata_o),
    .ctrl_rvalid_i(ctrl_rvalid_i), .ctrl_rdata_i(ctrl_rdata_i), .error_o(error_o)
  );

  // Response scoreboard: every response must match the oldest expected entry.
  always @(negedge clk) begin
    if (rsp_valid_o !== 3'b000) begin
      tests++;
      if (exp_rsp.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected: rsp_valid_o=%b data=%h, required no response", rsp_valid_o, rsp_rdata_o);
      end else begin
        mon_e = exp_rsp.pop_front();
        if (rsp_valid_o !== (3'b001 << mon_e.port) || rsp_rdata_o !== mon_e.data) begin
          fails++;
          $display("FAIL rsp_match: got valid=%b data=%h, required valid=%b data=%h",
                   rsp_valid_o, rsp_rdata_o, 3'b001 << mon_e.port, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // One clock: log observed grants, advance, then drive the controller return for this cycle.
  task automatic step();
    logic [2:0] rdy;
    logic       acc;
    rsp_t       e;
    #1;
    rdy = req_ready_o;
    acc = ctrl_valid_o && ctrl_ready_i && !ctrl_we_o && !reset_i;
    for (int n = 0; n < 3; n++) if (rdy[n]) grant_log.push_back(n);
    @(posedge clk);
    #1;
    if (auto_ret && acc && iss_q.size() > 0) begin
      e.port = 2'(iss_q.pop_front());
      e.data = $urandom;
      exp_rsp.push_back(e);
      ctrl_rvalid_i = 1'b1;
      ctrl_rdata_i  = e.data;
    end else begin
      ctrl_rvalid_i = 1'b0;
    end
  endtask

  task automatic ret(input logic [DW-1:0] d);
    rsp_t e;
    e.port = 2'(iss_q.pop_front());
    e.data = d;
    exp_rsp.push_back(e);
    ctrl_rvalid_i = 1'b1;
    ctrl_rdata_i  = d;
    step();
  endtask

  task automatic set_port(input int n, input logic v, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid_i[n]          = v;
    req_we_i[n]             = we;
    req_addr_i[n*AW +: AW]  = a;
    req_wdata_i[n*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset_i       = 1'b1;
    req_valid_i   = 3'b000;
    ctrl_rvalid_i = 1'b0;
    step();
    step();
    reset_i = 1'b0;
    grant_log.delete();
    iss_q.delete();
  endtask

  task automatic test_reset();
    reset_i       = 1'b1;
    req_valid_i   = 3'b111;
    req_we_i      = 3'b000;
    ctrl_ready_i  = 1'b1;
    ctrl_rvalid_i = 1'b1;
    ctrl_rdata_i  = 32'h1111_2222;
    step();
    ctrl_rvalid_i = 1'b1;
    step();
    #1;
    tests++; if (req_ready_o !== 3'b000) begin fails++; $display("FAIL reset_req_ready: got %b, required 000", req_ready_o); end
    tests++; if (ctrl_valid_o !== 1'b0) begin fails++; $display("FAIL reset_ctrl_valid: got %b, required 0", ctrl_valid_o); end
    tests++; if (rsp_valid_o !== 3'b000 || rsp_rdata_o !== '0) begin fails++; $display("FAIL reset_rsp: got %b/%h, required 000/0", rsp_valid_o, rsp_rdata_o); end
    tests++; if ({ctrl_we_o, ctrl_addr_o, ctrl_wdata_o} !== '0) begin fails++; $display("FAIL reset_ctrl_fields: got %b/%h/%h, required 0/0/0", ctrl_we_o, ctrl_addr_o, ctrl_wdata_o); end
    tests++; if (error_o !== 1'b0) begin fails++; $display("FAIL reset_error: got %b, required 0", error_o); end
    reset_i     = 1'b0;
    req_valid_i = 3'b000;
    step();
  endtask

  task automatic test_round_robin();
    logic exp_v;
    int   pulses = 0;
    do_reset();
    set_port(0, 1'b1, 1'b0, 24'h000100, '0);
    set_port(1, 1'b1, 1'b0, 24'h000200, '0);
    set_port(2, 1'b1, 1'b0, 24'h000300, '0);
    ctrl_ready_i = 1'b1;
    auto_ret     = 1'b1;
    for (int k = 0; k < 6; k++) iss_q.push_back(k % 3);
    for (int k = 0; k < 12; k++) begin
      step();
      exp_v = (k % 2 == 0);
      tests++;
      if (ctrl_valid_o !== exp_v) begin fails++; $display("FAIL rr_ctrl_valid: cycle %0d got %b, required %b", k, ctrl_valid_o, exp_v); end
      if (ctrl_valid_o === 1'b1) begin
        pulses++;
        tests++;
        if (ctrl_addr_o !== AW'(((k / 2) % 3 + 1) * 256)) begin
          fails++; $display("FAIL rr_addr: cycle %0d got %h, required %h", k, ctrl_addr_o, ((k / 2) % 3 + 1) * 256);
        end
      end
    end
    req_valid_i = 3'b000;
    step(); step(); step();
    auto_ret = 1'b0;
    tests++; if (pulses != 6) begin fails++; $display("FAIL rr_pulses: got %0d, required 6", pulses); end
    tests++; if (grant_log.size() != 6) begin fails++; $display("FAIL rr_grant_count: got %0d, required 6", grant_log.size()); end
    for (int i = 0; i < grant_log.size() && i < 6; i++) begin
      tests++;
      if (grant_log[i] != i % 3) begin fails++; $display("FAIL rr_order: grant %0d got port %0d, required %0d", i, grant_log[i], i % 3); end
    end
    tests++; if (exp_rsp.size() != 0) begin fails++; $display("FAIL rr_rsp_missing: %0d responses outstanding, required 0", exp_rsp.size()); end
  endtask

  task automatic test_read_write_mix();
    do_reset();
    ctrl_ready_i = 1'b1;
    set_port(1, 1'b1, 1'b0, 24'h000010, '0);
    set_port(2, 1'b1, 1'b1, 24'h000020, 32'h0000_1234);
    #1;
    tests++; if (req_ready_o !== 3'b010) begin fails++; $display("FAIL mix_grant_p1: got %b, required 010", req_ready_o); end
    iss_q.push_back(1);
    step();
    set_port(1, 1'b0, 1'b0, '0, '0);
    tests++; if ({ctrl_valid_o, ctrl_we_o, ctrl_addr_o} !== {1'b1, 1'b0, 24'h000010}) begin fails++; $display("FAIL mix_read_cmd: got v=%b we=%b a=%h, required 1/0/000010", ctrl_valid_o, ctrl_we_o, ctrl_addr_o); end
    step();
    #1;
    tests++; if (req_ready_o !== 3'b100) begin fails++; $display("FAIL mix_grant_p2: got %b, required 100", req_ready_o); end
    step();
    set_port(2, 1'b0, 1'b0, '0, '0);
    tests++; if ({ctrl_we_o, ctrl_addr_o, ctrl_wdata_o} !== {1'b1, 24'h000020, 32'h0000_1234}) begin fails++; $display("FAIL mix_write_cmd: got we=%b a=%h d=%h, required 1/000020/00001234", ctrl_we_o, ctrl_addr_o, ctrl_wdata_o); end
    step();
    ret(32'hCAFE_BABE);
    tests++; if (rsp_valid_o !== 3'b010 || rsp_rdata_o !== 32'hCAFE_BABE) begin fails++; $display("FAIL mix_rsp: got %b/%h, required 010/cafebabe", rsp_valid_o, rsp_rdata_o); end
    step(); step();
    tests++; if (rsp_valid_o !== 3'b000 || exp_rsp.size() != 0) begin fails++; $display("FAIL mix_rsp_after: got %b with %0d pending, required 000 with 0", rsp_valid_o, exp_rsp.size()); end
  endtask

  task automatic test_stall();
    do_reset();
    ctrl_ready_i = 1'b0;
    set_port(0, 1'b1, 1'b1, 24'h0ABCDE, 32'h55AA_55AA);
    step();
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b1, 1'b1, 24'h000777, 32'h1);
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++;
      if ({ctrl_valid_o, ctrl_we_o, ctrl_addr_o, ctrl_wdata_o} !== {1'b1, 1'b1, 24'h0ABCDE, 32'h55AA_55AA}) begin
        fails++; $display("FAIL stall_hold: cycle %0d got v=%b we=%b a=%h d=%h", k, ctrl_valid_o, ctrl_we_o, ctrl_addr_o, ctrl_wdata_o);
      end
      tests++; if (req_ready_o !== 3'b000) begin fails++; $display("FAIL stall_ready: cycle %0d got %b, required 000", k, req_ready_o); end
      step();
    end
    ctrl_ready_i = 1'b1;
    #1;
    tests++; if (ctrl_valid_o !== 1'b1) begin fails++; $display("FAIL stall_valid6: got %b, required 1", ctrl_valid_o); end
    step();
    #1;
    tests++; if (ctrl_valid_o !== 1'b0 || req_ready_o !== 3'b010) begin fails++; $display("FAIL stall_accept: got v=%b ready=%b, required 0/010", ctrl_valid_o, req_ready_o); end
    step();
    set_port(1, 1'b0, 1'b0, '0, '0);
    step();
    tests++; if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin fails++; $display("FAIL stall_grants: got %0d grants, required ports 0 then 1", grant_log.size()); end
  endtask

  task automatic test_tag_full();
    do_reset();
    ctrl_ready_i = 1'b1;
    for (int i = 0; i < TD; i++) begin
      set_port(0, 1'b1, 1'b0, AW'(i), '0);
      iss_q.push_back(0);
      step();
      set_port(0, 1'b0, 1'b0, '0, '0);
      step();
    end
    set_port(0, 1'b1, 1'b0, 24'h000050, '0);
    set_port(2, 1'b1, 1'b1, 24'h000060, 32'h99);
    #1;
    tests++; if (req_ready_o !== 3'b100) begin fails++; $display("FAIL full_write_grant: got %b, required 100", req_ready_o); end
    step();
    set_port(2, 1'b0, 1'b0, '0, '0);
    step();
    #1;
    tests++; if (req_ready_o !== 3'b000) begin fails++; $display("FAIL full_read_blocked: got %b, required 000", req_ready_o); end
    ret(32'hA000_0001);
    #1;
    tests++; if (req_ready_o !== 3'b001) begin fails++; $display("FAIL full_read_freed: got %b, required 001", req_ready_o); end
    iss_q.push_back(0);
    step();
    set_port(0, 1'b0, 1'b0, '0, '0);
    step();
  endtask

  task automatic test_push_pop_wrap();
    rsp_t e;
    ret(32'hB000_0001);
    set_port(1, 1'b1, 1'b0, 24'h000070, '0);
    e.port = 2'(iss_q.pop_front());
    e.data = 32'hB000_0002;
    exp_rsp.push_back(e);
    iss_q.push_back(1);
    ctrl_rvalid_i = 1'b1;
    ctrl_rdata_i  = e.data;
    #1;
    tests++; if (req_ready_o !== 3'b010) begin fails++; $display("FAIL pp_grant: got %b, required 010", req_ready_o); end
    step();
    set_port(1, 1'b0, 1'b0, '0, '0);
    step();
    set_port(2, 1'b1, 1'b0, 24'h000080, '0);
    #1;
    tests++; if (req_ready_o !== 3'b100) begin fails++; $display("FAIL pp_count3: got %b, required 100", req_ready_o); end
    iss_q.push_back(2);
    step();
    set_port(2, 1'b0, 1'b0, '0, '0);
    step();
    set_port(0, 1'b1, 1'b0, 24'h000090, '0);
    #1;
    tests++; if (req_ready_o !== 3'b000) begin fails++; $display("FAIL pp_count4_blocked: got %b, required 000", req_ready_o); end
    step(); step();
    set_port(0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < TD; i++) ret(32'hC000_0000 + DW'(i));
    step(); step();
    tests++; if (exp_rsp.size() != 0 || error_o !== 1'b0) begin fails++; $display("FAIL pp_drain: %0d pending error=%b, required 0/0", exp_rsp.size(), error_o); end
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    ctrl_ready_i = 1'b0;
    set_port(0, 1'b1, 1'b0, 24'h000033, '0);
    step();
    set_port(0, 1'b0, 1'b0, '0, '0);
    tests++; if (ctrl_valid_o !== 1'b1) begin fails++; $display("FAIL mid_issue_valid: got %b, required 1", ctrl_valid_o); end
    reset_i = 1'b1;
    step();
    set_port(1, 1'b1, 1'b1, 24'h000044, 32'h4);
    #1;
    tests++; if (req_ready_o !== 3'b000 || ctrl_valid_o !== 1'b0 || ctrl_addr_o !== '0) begin fails++; $display("FAIL mid_reset_state: ready=%b v=%b a=%h, required 000/0/0", req_ready_o, ctrl_valid_o, ctrl_addr_o); end
    reset_i = 1'b0;
    set_port(1, 1'b0, 1'b0, '0, '0);
    ctrl_ready_i = 1'b1;
    iss_q.delete();
    step(); step();
    tests++; if (ctrl_valid_o !== 1'b0) begin fails++; $display("FAIL mid_dropped: got %b, required 0", ctrl_valid_o); end
    ctrl_rvalid_i = 1'b1;
    ctrl_rdata_i  = 32'h5555_0000;
    step();
    tests++; if (error_o !== 1'b1 || rsp_valid_o !== 3'b000) begin fails++; $display("FAIL mid_tag_discard: error=%b rsp=%b, required 1/000", error_o, rsp_valid_o); end
  endtask

  task automatic test_error_flag();
    do_reset();
    tests++; if (error_o !== 1'b0) begin fails++; $display("FAIL err_clear: got %b, required 0", error_o); end
    ctrl_rvalid_i = 1'b1;
    ctrl_rdata_i  = 32'hDEAD_0000;
    step();
    tests++; if (rsp_valid_o !== 3'b000 || error_o !== 1'b1) begin fails++; $display("FAIL err_set: rsp=%b error=%b, required 000/1", rsp_valid_o, error_o); end
    step(); step(); step();
    tests++; if (error_o !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b, required 1", error_o); end
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    step();
    tests++; if (error_o !== 1'b0) begin fails++; $display("FAIL err_reset: got %b, required 0", error_o); end
  endtask

  initial begin
    reset_i       = 1'b1;
    req_valid_i   = 3'b000;
    req_we_i      = 3'b000;
    req_addr_i    = '0;
    req_wdata_i   = '0;
    ctrl_ready_i  = 1'b0;
    ctrl_rvalid_i = 1'b0;
    ctrl_rdata_i  = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_round_robin();
    test_read_write_mix();
    test_stall();
    test_tag_full();
    test_push_pop_wrap();
    test_reset_mid_issue();
    test_error_flag();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
